// File: rtl/seq_divider_8by4.sv
// Iterative unsigned restoring divider: WIDTH_N-bit dividend by WIDTH_D-bit divisor,
// one quotient bit per clock behind a start/busy/done handshake.
module seq_divider_8by4 #(
    parameter int WIDTH_N = 8,
    parameter int WIDTH_D = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_by_zero
);
    localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH_N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH_N-1:0] dvd_q, dvd_d;
    logic [WIDTH_D-1:0] dvs_q, dvs_d;
    logic [WIDTH_D-1:0] pr_q, pr_d;
    logic [WIDTH_N-1:0] q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH_N-1:0] quotient_q, quotient_d;
    logic [WIDTH_D-1:0] remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    logic               accept;
    logic [WIDTH_D:0]   pr_shift;
    logic               ge;
    logic [WIDTH_D-1:0] pr_next;
    logic [WIDTH_N-1:0] q_next;

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        pr_d        = pr_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        accept   = start && (state_q != RUN);
        // After each step PR < divisor, so only the shifted-in value needs the extra bit.
        pr_shift = {pr_q, dvd_q[WIDTH_N-1]};
        ge       = (pr_shift >= {1'b0, dvs_q});
        pr_next  = ge ? WIDTH_D'(pr_shift - {1'b0, dvs_q}) : pr_shift[WIDTH_D-1:0];
        q_next   = {q_q[WIDTH_N-2:0], ge};

        if (accept) begin
            state_d = RUN;
            dvd_d   = dividend;
            dvs_d   = divisor;
            pr_d    = '0;
            q_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            zero_d  = (divisor == '0);
            busy_d  = (divisor != '0);
        end else if (state_q == RUN) begin
            if (zero_q) begin
                // Zero divisor: one silent cycle, then report without iterating.
                state_d     = DONE;
                done_d      = 1'b1;
                zero_d      = 1'b0;
                quotient_d  = '1;
                remainder_d = '0;
                dbz_d       = 1'b1;
            end else begin
                pr_d  = pr_next;
                q_d   = q_next;
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    quotient_d  = q_next;
                    remainder_d = pr_next;
                end else begin
                    busy_d = 1'b1;
                end
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            pr_q        <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            pr_q        <= pr_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule
